disk_io_arbiter: RTL and testbench

Shares the single IO-controller (ARM) disk-transfer channel between the floppy controller and the ACSI hard-disk controller.
- Detects a pending request from either source.
- Arbitrates round-robin between the two sources.
- Snapshots the granted source's 5 status bytes via its status_sel bus into a local buffer.
- Presents the request to the IO controller.
- Returns the completion as a one-cycle dma_ack pulse to the owning source.
- Sits between the floppy/ACSI blocks and the IO-controller SPI command decoder.

---
 rtl/disk_io_pkg.sv | 42 ++++
 rtl/disk_io_arbiter_if.sv | 47 ++++
 rtl/disk_io_rr_arb.sv | 35 +++
 rtl/disk_io_arbiter.sv | 172 +++++++++++++++++
 tb/tb_disk_io_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disk_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disk_io_pkg
// Description : Shared definitions for the disk IO arbiter slice: FSM state
//               encoding, source codes, default status-byte count and the
//               meaning of each captured status byte.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package disk_io_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CAPTURE = ST_CAPTURE,
    S_REQ     = ST_REQ,
    S_ACK     = ST_ACK,
    S_HOLD    = ST_HOLD
  } state_t;

  // Request owner codes (also the value presented on io_src)
  localparam logic SRC_FDC  = 1'b0;
  localparam logic SRC_ACSI = 1'b1;

  // Number of status bytes snapshotted per request
  localparam int NUM_STAT_DEFAULT = 5;

  // Status byte layout as seen through status_sel
  localparam logic [2:0] STAT_IDX_CMD    = 3'd0;
  localparam logic [2:0] STAT_IDX_TRACK  = 3'd1;
  localparam logic [2:0] STAT_IDX_SECTOR = 3'd2;
  localparam logic [2:0] STAT_IDX_DATA   = 3'd3;
  localparam logic [2:0] STAT_IDX_DSW    = 3'd4;  // drive/side/wait, bit 0 = io_wait

endpackage : disk_io_pkg
`default_nettype wire

// File: rtl/disk_io_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : disk_io_arbiter_if
// Description : Bundle of the floppy, ACSI and IO-controller signals that
//               connect to the disk IO arbiter.
// Modports    : master - arbiter side (drives selects, acks, io_req/src/data)
//               slave  - environment side (sources and IO controller)
// Signals     : fdc_io_wait/fdc_status_byte/fdc_status_sel/fdc_dma_ack,
//               acsi_io_wait/acsi_status_byte/acsi_status_sel/acsi_dma_ack,
//               io_req/io_src/io_rd_idx/io_rd_data/io_ack/io_timeout
// Revision    : 1.0 - initial release
// ============================================================================
interface disk_io_arbiter_if;

  logic       fdc_io_wait;
  logic [7:0] fdc_status_byte;
  logic [2:0] fdc_status_sel;
  logic       fdc_dma_ack;

  logic       acsi_io_wait;
  logic [7:0] acsi_status_byte;
  logic [2:0] acsi_status_sel;
  logic       acsi_dma_ack;

  logic       io_req;
  logic       io_src;
  logic [2:0] io_rd_idx;
  logic [7:0] io_rd_data;
  logic       io_ack;
  logic       io_timeout;

  modport master (
    input  fdc_io_wait, fdc_status_byte, acsi_io_wait, acsi_status_byte,
           io_rd_idx, io_ack,
    output fdc_status_sel, fdc_dma_ack, acsi_status_sel, acsi_dma_ack,
           io_req, io_src, io_rd_data, io_timeout
  );

  modport slave (
    output fdc_io_wait, fdc_status_byte, acsi_io_wait, acsi_status_byte,
           io_rd_idx, io_ack,
    input  fdc_status_sel, fdc_dma_ack, acsi_status_sel, acsi_dma_ack,
           io_req, io_src, io_rd_data, io_timeout
  );

endinterface : disk_io_arbiter_if
`default_nettype wire

// File: rtl/disk_io_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : disk_io_rr_arb
// Description : Combinational two-way round-robin grant between the floppy
//               and ACSI requesters.
// Ports       : req_fdc_i     - floppy request
//               req_acsi_i    - ACSI request
//               rr_last_i     - source granted last time
//               grant_valid_o - at least one request present
//               grant_src_o   - winning source (SRC_FDC / SRC_ACSI)
// Revision    : 1.0 - initial release
// ============================================================================
module disk_io_rr_arb
  import disk_io_pkg::*;
(
  input  logic req_fdc_i,
  input  logic req_acsi_i,
  input  logic rr_last_i,
  output logic grant_valid_o,
  output logic grant_src_o
);

  always_comb begin
    grant_valid_o = req_fdc_i | req_acsi_i;
    grant_src_o   = SRC_FDC;
    if (req_fdc_i && req_acsi_i) begin
      // Source codes are 0/1, so the loser of the last tie is simply ~rr_last
      grant_src_o = ~rr_last_i;
    end else if (req_acsi_i) begin
      grant_src_o = SRC_ACSI;
    end
  end

endmodule : disk_io_rr_arb
`default_nettype wire

// File: rtl/disk_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disk_io_arbiter
// Description : Shares the IO-controller disk-transfer channel between the
//               floppy and ACSI controllers. Grants round-robin, snapshots
//               the owner's status bytes, raises io_req, and returns the
//               completion as a one-cycle dma_ack pulse to the owner.
// Ports       : clk   - system clock (8 MHz domain)
//               reset - synchronous, active-high reset
//               bus   - disk_io_arbiter_if.master (sources + IO controller)
// Parameters  : TIMEOUT_CYCLES - IO-controller response timeout in clocks
//               NUM_STAT       - status bytes captured per request
// Macro       : DISK_IO_TIMEOUT_EN - enables the REQ response timeout and
//               the sticky io_timeout flag (otherwise io_timeout is 0)
// Revision    : 1.0 - initial release
// ============================================================================
module disk_io_arbiter
  import disk_io_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd80000000,
  parameter int          NUM_STAT       = NUM_STAT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  disk_io_arbiter_if.master         bus
);

  state_t     state_q, state_d;
  logic       io_src_q, io_src_d;
  logic       rr_last_q, rr_last_d;
  logic [2:0] cap_idx_q, cap_idx_d;
  logic [7:0] snap_q [NUM_STAT];

  logic       grant_valid;
  logic       grant_src;
  logic       grant_fire;
  logic       cap_last;
  logic [7:0] cap_byte;
  logic       tmo_expire;

  disk_io_rr_arb u_rr_arb (
    .req_fdc_i     (bus.fdc_io_wait),
    .req_acsi_i    (bus.acsi_io_wait),
    .rr_last_i     (rr_last_q),
    .grant_valid_o (grant_valid),
    .grant_src_o   (grant_src)
  );

  assign grant_fire = (state_q == S_IDLE) && grant_valid;
  assign cap_last   = (cap_idx_q == 3'(NUM_STAT - 1));
  assign cap_byte   = (io_src_q == SRC_ACSI) ? bus.acsi_status_byte
                                             : bus.fdc_status_byte;

`ifdef DISK_IO_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        io_timeout_q;

  // Counter is zero on the first REQ cycle, so expiry on the value
  // TIMEOUT_CYCLES-1 leaves REQ after exactly TIMEOUT_CYCLES cycles.
  assign tmo_expire = (state_q == S_REQ) && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_REQ) begin
      tmo_cnt_d = (tmo_cnt_q == 32'hFFFF_FFFF) ? tmo_cnt_q : tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q    <= '0;
      io_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (grant_fire) begin
        io_timeout_q <= 1'b0;
      end else if (tmo_expire && !bus.io_ack) begin
        // A simultaneous io_ack wins: the transfer did complete
        io_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.io_timeout = io_timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expire     = 1'b0;
  assign bus.io_timeout = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    io_src_d  = io_src_q;
    rr_last_d = rr_last_q;
    cap_idx_d = cap_idx_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          io_src_d  = grant_src;
          rr_last_d = grant_src;
          cap_idx_d = '0;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cap_last) begin
          state_d = S_REQ;
        end else begin
          cap_idx_d = cap_idx_q + 3'd1;
        end
      end
      S_REQ: begin
        if (bus.io_ack || tmo_expire) begin
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      io_src_q  <= SRC_FDC;
      rr_last_q <= SRC_ACSI;  // floppy wins the first tie
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      io_src_q  <= io_src_d;
      rr_last_q <= rr_last_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  // Snapshot buffer: written only while capturing, holds afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAT; i++) begin
        snap_q[i] <= 8'h00;
      end
    end else if (state_q == S_CAPTURE) begin
      snap_q[cap_idx_q] <= cap_byte;
    end
  end

  // Outputs
  always_comb begin
    bus.io_req          = (state_q == S_REQ);
    bus.io_src          = io_src_q;
    bus.fdc_dma_ack     = (state_q == S_ACK) && (io_src_q == SRC_FDC);
    bus.acsi_dma_ack    = (state_q == S_ACK) && (io_src_q == SRC_ACSI);
    bus.fdc_status_sel  = 3'd0;
    bus.acsi_status_sel = 3'd0;
    if (state_q == S_CAPTURE) begin
      if (io_src_q == SRC_ACSI) begin
        bus.acsi_status_sel = cap_idx_q;
      end else begin
        bus.fdc_status_sel = cap_idx_q;
      end
    end
    bus.io_rd_data = 8'h00;
    if (32'(bus.io_rd_idx) < NUM_STAT) begin
      bus.io_rd_data = snap_q[bus.io_rd_idx];
    end
  end

endmodule : disk_io_arbiter
`default_nettype wire

// File: tb/tb_disk_io_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_disk_io_arbiter
// Description : Self-checking bench for disk_io_arbiter. Hand sequences for
//               capture timing, completion, spurious acks, reset in REQ and
//               the response timeout, then a vector table of back-to-back
//               transactions checked through an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disk_io_arbiter;
  import disk_io_pkg::*;

  localparam logic [31:0] TMO   = 32'd100;
  localparam int          NSTAT = 5;
  localparam int          NVEC  = 8;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  disk_io_arbiter_if bus();

  // Sources present base+sel on their status byte bus
  logic [7:0] fdc_base;
  logic [7:0] acsi_base;
  assign bus.fdc_status_byte  = fdc_base  + {5'b0, bus.fdc_status_sel};
  assign bus.acsi_status_byte = acsi_base + {5'b0, bus.acsi_status_sel};

  disk_io_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .NUM_STAT       (NSTAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       fdc_w;
    logic       acsi_w;
    logic [7:0] fdc_b;
    logic [7:0] acsi_b;
    int         ack_dly;
    logic       exp_src;
  } vec_t;

  typedef struct {
    logic       src;
    logic [7:0] base;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  exp_t exp_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for io_req; returns the number of clocks waited
  task automatic wait_req(input string name, output int cnt);
    cnt = 0;
    while (bus.io_req !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    chk(name, 32'(bus.io_req), 32'd1);
  endtask

  // Sweep all read indices; out-of-range indices must read 0
  task automatic chk_snap(input string name, input logic [7:0] base, input bit zero);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      bus.io_rd_idx = 3'(i);
      #1;
      e = (i < NSTAT && !zero) ? base + 8'(i) : 8'h00;
      chk($sformatf("%s_snap%0d", name, i), 32'(bus.io_rd_data), 32'(e));
    end
    bus.io_rd_idx = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table (rr_last starts at ACSI after reset)
    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h50, 0, SRC_FDC};
    vecs[1] = '{1'b1, 1'b1, 8'h18, 8'h58, 1, SRC_ACSI};
    vecs[2] = '{1'b1, 1'b1, 8'h20, 8'h60, 2, SRC_FDC};
    vecs[3] = '{1'b0, 1'b1, 8'h28, 8'h68, 0, SRC_ACSI};
    vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h70, 3, SRC_FDC};
    vecs[5] = '{1'b1, 1'b0, 8'h38, 8'h78, 1, SRC_FDC};
    vecs[6] = '{1'b1, 1'b1, 8'h40, 8'hC0, 0, SRC_ACSI};
    vecs[7] = '{1'b0, 1'b1, 8'h48, 8'hE8, 2, SRC_ACSI};

    bus.fdc_io_wait  = 1'b0;
    bus.acsi_io_wait = 1'b0;
    bus.io_ack       = 1'b0;
    bus.io_rd_idx    = 3'd0;
    fdc_base         = 8'h00;
    acsi_base        = 8'h00;
    do_reset();

    // ---------------- reset state
    chk("rst_io_req", 32'(bus.io_req), 0);
    chk("rst_io_src", 32'(bus.io_src), 0);
    chk("rst_acks", 32'({bus.fdc_dma_ack, bus.acsi_dma_ack}), 0);
    chk("rst_sels", 32'({bus.fdc_status_sel, bus.acsi_status_sel}), 0);
    chk("rst_timeout", 32'(bus.io_timeout), 0);
    chk_snap("rst", 8'h00, 1'b1);

    // ---------------- floppy only: capture timing and snapshot
    fdc_base        = 8'h80;
    bus.fdc_io_wait = 1'b1;
    for (int i = 0; i < NSTAT; i++) begin
      step();
      chk($sformatf("fdc_sel_%0d", i), 32'(bus.fdc_status_sel), 32'(i));
      chk($sformatf("fdc_acsi_sel_%0d", i), 32'(bus.acsi_status_sel), 0);
      chk($sformatf("fdc_noreq_%0d", i), 32'(bus.io_req), 0);
    end
    step();
    chk("fdc_req_rise", 32'(bus.io_req), 1);
    chk("fdc_src", 32'(bus.io_src), 32'(SRC_FDC));
    chk_snap("fdc", 8'h80, 1'b0);

    // ---------------- completion, wait held: re-request after HOLD+IDLE
    bus.io_ack = 1'b1;
    step();
    bus.io_ack = 1'b0;
    chk("cmp_fdc_ack", 32'(bus.fdc_dma_ack), 1);
    chk("cmp_acsi_ack", 32'(bus.acsi_dma_ack), 0);
    chk("cmp_req_low", 32'(bus.io_req), 0);
    step();
    chk("cmp_ack_once", 32'({bus.fdc_dma_ack, bus.acsi_dma_ack}), 0);
    wait_req("rereq", n);
    chk("rereq_latency", 32'(n), 32'd7);
    bus.io_ack = 1'b1;
    step();
    bus.io_ack      = 1'b0;
    bus.fdc_io_wait = 1'b0;
    chk("rereq_fdc_ack", 32'(bus.fdc_dma_ack), 1);
    step(); step();

    // ---------------- spurious io_ack in IDLE and CAPTURE
    bus.io_ack = 1'b1;
    step();
    chk("sp_idle_acks", 32'({bus.fdc_dma_ack, bus.acsi_dma_ack}), 0);
    chk("sp_idle_req", 32'(bus.io_req), 0);
    fdc_base        = 8'h40;
    bus.fdc_io_wait = 1'b1;
    step();
    for (int i = 0; i < NSTAT; i++) begin
      bus.io_ack = (i < 3);
      chk($sformatf("sp_cap_sel_%0d", i), 32'(bus.fdc_status_sel), 32'(i));
      chk($sformatf("sp_cap_req_%0d", i), 32'(bus.io_req), 0);
      chk($sformatf("sp_cap_acks_%0d", i), 32'({bus.fdc_dma_ack, bus.acsi_dma_ack}), 0);
      step();
    end
    chk("sp_req_rise", 32'(bus.io_req), 1);
    chk_snap("sp", 8'h40, 1'b0);
    bus.io_ack = 1'b1;
    step();
    bus.io_ack      = 1'b0;
    bus.fdc_io_wait = 1'b0;
    chk("sp_fdc_ack", 32'(bus.fdc_dma_ack), 1);
    step(); step();

    // ---------------- reset while in REQ
    acsi_base        = 8'hA0;
    bus.acsi_io_wait = 1'b1;
    wait_req("rreq_req", n);
    chk("rreq_src", 32'(bus.io_src), 32'(SRC_ACSI));
    chk_snap("rreq_pre", 8'hA0, 1'b0);
    reset = 1'b1;
    step();
    chk("rreq_req_low", 32'(bus.io_req), 0);
    chk("rreq_no_ack", 32'({bus.fdc_dma_ack, bus.acsi_dma_ack}), 0);
    chk_snap("rreq_clr", 8'h00, 1'b1);
    reset     = 1'b0;
    acsi_base = 8'hA8;
    wait_req("rreq_fresh_req", n);
    chk("rreq_fresh_src", 32'(bus.io_src), 32'(SRC_ACSI));
    chk_snap("rreq_fresh", 8'hA8, 1'b0);
    bus.io_ack = 1'b1;
    step();
    bus.io_ack       = 1'b0;
    bus.acsi_io_wait = 1'b0;
    chk("rreq_acsi_ack", 32'(bus.acsi_dma_ack), 1);
    chk("rreq_fdc_ack", 32'(bus.fdc_dma_ack), 0);
    step(); step();

    // ---------------- response timeout
    fdc_base        = 8'h20;
    bus.fdc_io_wait = 1'b1;
    wait_req("tmo_req", n);
`ifdef DISK_IO_TIMEOUT_EN
    n = 1;
    while (n < 300) begin
      step();
      if (bus.io_req !== 1'b1) break;
      n++;
    end
    chk("tmo_req_cycles", 32'(n), TMO);
    chk("tmo_flag", 32'(bus.io_timeout), 1);
    chk("tmo_fdc_ack", 32'(bus.fdc_dma_ack), 1);
    chk("tmo_acsi_ack", 32'(bus.acsi_dma_ack), 0);
    bus.fdc_io_wait = 1'b0;
    step();
    chk("tmo_ack_once", 32'(bus.fdc_dma_ack), 0);
    chk("tmo_sticky", 32'(bus.io_timeout), 1);
    step();
    acsi_base        = 8'h30;
    bus.acsi_io_wait = 1'b1;
    step();
    chk("tmo_clr_on_grant", 32'(bus.io_timeout), 0);
    wait_req("tmo_next_req", n);
    bus.io_ack = 1'b1;
    step();
    bus.io_ack       = 1'b0;
    bus.acsi_io_wait = 1'b0;
    chk("tmo_next_ack", 32'(bus.acsi_dma_ack), 1);
    chk("tmo_next_flag", 32'(bus.io_timeout), 0);
    step(); step();
`else
    for (int k = 0; k < 150; k++) step();
    chk("notmo_req_held", 32'(bus.io_req), 1);
    chk("notmo_flag", 32'(bus.io_timeout), 0);
    bus.io_ack = 1'b1;
    step();
    bus.io_ack      = 1'b0;
    bus.fdc_io_wait = 1'b0;
    chk("notmo_fdc_ack", 32'(bus.fdc_dma_ack), 1);
    step(); step();
`endif

    // ---------------- table of back-to-back transactions
    do_reset();
    for (int v = 0; v < NVEC; v++) begin
      bus.fdc_io_wait  = vecs[v].fdc_w;
      bus.acsi_io_wait = vecs[v].acsi_w;
      fdc_base         = vecs[v].fdc_b;
      acsi_base        = vecs[v].acsi_b;
      exp_e.src        = vecs[v].exp_src;
      exp_e.base       = vecs[v].exp_src ? vecs[v].acsi_b : vecs[v].fdc_b;
      sb_q.push_back(exp_e);

      wait_req($sformatf("vec%0d_req", v), n);
      exp_e = sb_q.pop_front();
      chk($sformatf("vec%0d_src", v), 32'(bus.io_src), 32'(exp_e.src));
      chk_snap($sformatf("vec%0d", v), exp_e.base, 1'b0);
      for (int d = 0; d < vecs[v].ack_dly; d++) begin
        step();
        chk($sformatf("vec%0d_req_hold%0d", v, d), 32'(bus.io_req), 1);
      end
      bus.io_ack = 1'b1;
      step();
      bus.io_ack = 1'b0;
      chk($sformatf("vec%0d_fdc_ack", v), 32'(bus.fdc_dma_ack), 32'(exp_e.src == SRC_FDC));
      chk($sformatf("vec%0d_acsi_ack", v), 32'(bus.acsi_dma_ack), 32'(exp_e.src == SRC_ACSI));
      chk($sformatf("vec%0d_req_low", v), 32'(bus.io_req), 0);
      step();
      chk($sformatf("vec%0d_ack_once", v), 32'({bus.fdc_dma_ack, bus.acsi_dma_ack}), 0);
    end

    // ---------------- idle afterwards, snapshot retained
    bus.fdc_io_wait  = 1'b0;
    bus.acsi_io_wait = 1'b0;
    step(); step(); step();
    chk("end_req_low", 32'(bus.io_req), 0);
    chk("end_sb_empty", 32'(sb_q.size()), 0);
    chk_snap("end_hold", vecs[NVEC-1].acsi_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_disk_io_arbiter
`default_nettype wire
